// File: rtl/dma_ram_arbiter.sv
// rtl/dma_ram_arbiter.sv - round-robin single-port RAM arbiter for the CPU and IO DMA paths
module dma_ram_arbiter #(
  parameter int SZ        = 8,
  parameter int WSZ       = 8,
  parameter int MAX_BURST = 4
) (
  input  logic           ram_clk,
  input  logic           rst,
  input  logic           cpu_req,
  input  logic [SZ-1:0]  cpu_addr,
  input  logic           cpu_w_notr,
  input  logic [WSZ-1:0] cpu_wdata,
  output logic           cpu_gnt,
  output logic [WSZ-1:0] cpu_rdata,
  output logic           cpu_rvalid,
  input  logic           io_req,
  input  logic [SZ-1:0]  io_addr,
  input  logic           io_w_notr,
  input  logic [WSZ-1:0] io_wdata,
  output logic           io_gnt,
  output logic [WSZ-1:0] io_rdata,
  output logic           io_rvalid,
  output logic           ram_en,
  output logic           ram_w_notr,
  output logic [SZ-1:0]  ram_addr,
  output logic [WSZ-1:0] ram_wdata,
  input  logic [WSZ-1:0] ram_rdata,
  output logic [1:0]     owner
);

  localparam int BW = $clog2(MAX_BURST) + 1;

  // State encoding doubles as the owner code: 00 none, 01 CPU, 10 IO.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CPU  = 2'b01,
    ST_IO   = 2'b10
  } state_t;

  state_t          state, state_nxt;
  logic            last_io, last_io_nxt;
  logic [BW-1:0]   burst_cnt, burst_nxt;
  logic [BW-1:0]   burst_inc;
  logic            burst_hit;
  logic            cpu_beat, io_beat, beat;
  logic            sel_w;
  logic [SZ-1:0]   sel_addr;
  logic [WSZ-1:0]  sel_wdata;
  logic            iss_rd, iss_io;
  logic            ret_rd, ret_io;

  assign cpu_gnt   = (state == ST_CPU);
  assign io_gnt    = (state == ST_IO);
  assign owner     = state;
  assign cpu_beat  = cpu_req && cpu_gnt;
  assign io_beat   = io_req && io_gnt;
  assign beat      = cpu_beat || io_beat;
  assign burst_inc = burst_cnt + BW'(1);
  assign burst_hit = (burst_inc == BW'(MAX_BURST));
  assign sel_w     = cpu_beat ? cpu_w_notr : io_w_notr;
  assign sel_addr  = cpu_beat ? cpu_addr   : io_addr;
  assign sel_wdata = cpu_beat ? cpu_wdata  : io_wdata;

  // Arbitration state, tie-break memory and burst counter registers.
  always_ff @(posedge ram_clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      last_io   <= 1'b1;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      last_io   <= last_io_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Next grant: round-robin with a burst cap that only bites when the other side waits.
  always_comb begin
    state_nxt   = state;
    burst_nxt   = burst_cnt;
    last_io_nxt = last_io;
    case (state)
      ST_IDLE: begin
        if (cpu_req && io_req) state_nxt = last_io ? ST_CPU : ST_IO;
        else if (cpu_req)      state_nxt = ST_CPU;
        else if (io_req)       state_nxt = ST_IO;
      end
      ST_CPU: begin
        if (!cpu_req)       state_nxt = io_req ? ST_IO : ST_IDLE;
        else if (burst_hit) begin
          if (io_req)       state_nxt = ST_IO;
          else              burst_nxt = '0;
        end else            burst_nxt = burst_inc;
      end
      ST_IO: begin
        if (!io_req)        state_nxt = cpu_req ? ST_CPU : ST_IDLE;
        else if (burst_hit) begin
          if (cpu_req)      state_nxt = ST_CPU;
          else              burst_nxt = '0;
        end else            burst_nxt = burst_inc;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (state_nxt != state) begin
      burst_nxt = '0;
      if (state == ST_CPU) last_io_nxt = 1'b0;
      if (state == ST_IO)  last_io_nxt = 1'b1;
    end
  end

  // Issue stage: register the beat onto the RAM port, with a read tag riding alongside.
  always_ff @(posedge ram_clk) begin
    if (!rst) begin
      ram_en     <= 1'b0;
      ram_w_notr <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      iss_rd     <= 1'b0;
      iss_io     <= 1'b0;
    end else begin
      ram_en     <= beat;
      ram_w_notr <= beat && sel_w;
      iss_rd     <= beat && !sel_w;
      iss_io     <= io_beat;
      if (beat) begin
        ram_addr  <= sel_addr;
        ram_wdata <= sel_wdata;
      end
    end
  end

  // Return stage: tag waits for RAM data, then the data is steered to the issuing side.
  always_ff @(posedge ram_clk) begin
    if (!rst) begin
      ret_rd     <= 1'b0;
      ret_io     <= 1'b0;
      cpu_rvalid <= 1'b0;
      io_rvalid  <= 1'b0;
      cpu_rdata  <= '0;
      io_rdata   <= '0;
    end else begin
      ret_rd     <= iss_rd;
      ret_io     <= iss_io;
      cpu_rvalid <= ret_rd && !ret_io;
      io_rvalid  <= ret_rd && ret_io;
      if (ret_rd && !ret_io) cpu_rdata <= ram_rdata;
      if (ret_rd && ret_io)  io_rdata  <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_dma_ram_arbiter.sv
// tb/tb_dma_ram_arbiter.sv - randomized self-checking bench for dma_ram_arbiter
module tb_dma_ram_arbiter;

  localparam int MB   = 4;
  localparam int NCYC = 2000;

  logic       ram_clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_w_notr, io_req, io_w_notr;
  logic [7:0] cpu_addr, cpu_wdata, io_addr, io_wdata, ram_rdata;
  logic       cpu_gnt, cpu_rvalid, io_gnt, io_rvalid;
  logic [7:0] cpu_rdata, io_rdata;
  logic       ram_en, ram_w_notr;
  logic [7:0] ram_addr, ram_wdata;
  logic [1:0] owner;

  dma_ram_arbiter #(.SZ(8), .WSZ(8), .MAX_BURST(MB)) dut (
    .ram_clk(ram_clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_w_notr(cpu_w_notr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .io_req(io_req), .io_addr(io_addr), .io_w_notr(io_w_notr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rdata(io_rdata), .io_rvalid(io_rvalid),
    .ram_en(ram_en), .ram_w_notr(ram_w_notr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .owner(owner)
  );

  always #5 ram_clk = ~ram_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Expected events scheduled by absolute cycle number.
  logic       x_en    [NCYC+4];
  logic       x_wn    [NCYC+4];
  logic [7:0] x_addr  [NCYC+4];
  logic [7:0] x_wdata [NCYC+4];
  int         rd_side [NCYC+4];
  int         rt_side [NCYC+4];
  logic [7:0] rt_data [NCYC+4];

  // Reference arbiter: owner 0 none / 1 CPU / 2 IO, beats taken in the current run, last holder.
  int         m_own, m_run, m_last;
  logic [7:0] h_addr, h_wdata, h_cdata, h_idata;

  function automatic int pick_next(int own, int run, int last, logic cr, logic ir);
    logic want_s, want_o;
    int   o;
    if (own == 0) begin
      if (cr && ir) return 3 - last;
      if (cr) return 1;
      if (ir) return 2;
      return 0;
    end
    o      = 3 - own;
    want_s = (own == 1) ? cr : ir;
    want_o = (own == 1) ? ir : cr;
    if (!want_s) return want_o ? o : 0;
    if (run + 1 == MB && want_o) return o;
    return own;
  endfunction

  initial begin
    logic       e_en, e_wn, e_cv, e_iv;
    int         nxt, b;
    logic       bw;
    logic [7:0] ba, bd;

    for (int i = 0; i < NCYC + 4; i++) begin
      x_en[i] = 0; x_wn[i] = 0; x_addr[i] = 0; x_wdata[i] = 0;
      rd_side[i] = 0; rt_side[i] = 0; rt_data[i] = 0;
    end
    m_own = 0; m_run = 0; m_last = 2;
    h_addr = 0; h_wdata = 0; h_cdata = 0; h_idata = 0;
    rst = 0; cpu_req = 0; io_req = 0; cpu_w_notr = 0; io_w_notr = 0;
    cpu_addr = 0; io_addr = 0; cpu_wdata = 0; io_wdata = 0; ram_rdata = 0;
    repeat (2) @(posedge ram_clk);

    for (int c = 0; c < NCYC; c++) begin
      @(posedge ram_clk);
      #1;
      cyc = c;

      e_en = x_en[c];
      e_wn = x_en[c] && x_wn[c];
      if (e_en) begin
        h_addr  = x_addr[c];
        h_wdata = x_wdata[c];
      end
      e_cv = (rt_side[c] == 1);
      e_iv = (rt_side[c] == 2);
      if (e_cv) h_cdata = rt_data[c];
      if (e_iv) h_idata = rt_data[c];
      chk("grant", {28'd0, owner, cpu_gnt, io_gnt},
          {28'd0, 2'(m_own), 1'(m_own == 1), 1'(m_own == 2)});
      chk("ram_port", {14'd0, ram_en, ram_w_notr, ram_addr, ram_wdata},
          {14'd0, e_en, e_wn, h_addr, h_wdata});
      chk("read_ret", {14'd0, cpu_rvalid, cpu_rdata, io_rvalid, io_rdata},
          {14'd0, e_cv, h_cdata, e_iv, h_idata});

      if (c == 0) chk("reset_outs", {8'd0, cpu_gnt, io_gnt, owner, ram_en, ram_w_notr, ram_addr,
                      ram_wdata, cpu_rvalid, io_rvalid}, 32'd0);
      if (c == 1) chk("first_gnt", {31'd0, cpu_gnt}, 32'd1);
      if (c == 2) chk("first_issue", {23'd0, ram_en, ram_addr}, {23'd0, 1'b1, 8'h10});
      if (c == 4) chk("first_return", {23'd0, cpu_rvalid, cpu_rdata}, {23'd0, 1'b1, 8'hA5});
      if (c == 5) chk("rvalid_pulse", {31'd0, cpu_rvalid}, 32'd0);

      if (c < 8) begin
        rst = 1; cpu_req = (c <= 1); cpu_addr = 8'h10; cpu_w_notr = 0; cpu_wdata = 0;
        io_req = 0; io_w_notr = 0; io_addr = 0; io_wdata = 0;
        ram_rdata = (c == 3) ? 8'hA5 : 8'($urandom);
      end else begin
        rst        = 1;
        cpu_addr   = 8'($urandom); cpu_wdata = 8'($urandom);
        io_addr    = 8'($urandom); io_wdata  = 8'($urandom);
        ram_rdata  = 8'($urandom);
        if (c < 60) begin
          cpu_req = 1; io_req = 1; cpu_w_notr = 1; io_w_notr = 1;
        end else if (c < 80) begin
          cpu_req = 0; io_req = 1; cpu_w_notr = 0; io_w_notr = 0;
        end else begin
          rst        = ($urandom_range(0, 63) != 0);
          cpu_req    = ($urandom_range(0, 9) < 7);
          io_req     = ($urandom_range(0, 9) < 7);
          cpu_w_notr = 1'($urandom);
          io_w_notr  = 1'($urandom);
        end
      end

      if (!rst) begin
        for (int k = c + 1; k <= c + 3; k++) begin
          x_en[k] = 0; rd_side[k] = 0; rt_side[k] = 0;
        end
        m_own = 0; m_run = 0; m_last = 2;
        h_addr = 0; h_wdata = 0; h_cdata = 0; h_idata = 0;
      end else begin
        b = (m_own == 1 && cpu_req) ? 1 : (m_own == 2 && io_req) ? 2 : 0;
        if (b != 0) begin
          bw = (b == 1) ? cpu_w_notr : io_w_notr;
          ba = (b == 1) ? cpu_addr   : io_addr;
          bd = (b == 1) ? cpu_wdata  : io_wdata;
          x_en[c+1] = 1; x_wn[c+1] = bw; x_addr[c+1] = ba; x_wdata[c+1] = bd;
          if (!bw) rd_side[c+2] = b;
        end
        if (rd_side[c] != 0) begin
          rt_side[c+1] = rd_side[c];
          rt_data[c+1] = ram_rdata;
        end
        nxt = pick_next(m_own, m_run, m_last, cpu_req, io_req);
        if (nxt != m_own) begin
          if (m_own != 0) m_last = m_own;
          m_run = 0;
          m_own = nxt;
        end else if (b != 0) begin
          m_run = (m_run + 1 == MB) ? 0 : m_run + 1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
